// File: rtl/prv32_alu_ctrl_stage.sv
// prv32 ALU control stage: decodes opcode/funct fields into an ALU
// function and operands, registered into the ID/EX boundary.
`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SUB  4'b0001
`define ALU_PASS 4'b0011
`define ALU_OR   4'b0100
`define ALU_AND  4'b0101
`define ALU_XOR  4'b0111
`define ALU_SRL  4'b1000
`define ALU_SLL  4'b1001
`define ALU_SRA  4'b1010
`define ALU_SLT  4'b1101
`define ALU_SLTU 4'b1111
`endif

module prv32_alu_ctrl_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic [XLEN-1:0] id_rs1,
    input  logic [XLEN-1:0] id_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      ex_alufn,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [4:0]      ex_shamt,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    function automatic logic [3:0] f3_alufn(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_r
    );
        logic [3:0] fn;
        unique case (f3)
            3'b000:  fn = (alt && is_r) ? `ALU_SUB : `ALU_ADD;
            3'b001:  fn = `ALU_SLL;
            3'b010:  fn = `ALU_SLT;
            3'b011:  fn = `ALU_SLTU;
            3'b100:  fn = `ALU_XOR;
            3'b101:  fn = alt ? `ALU_SRA : `ALU_SRL;
            3'b110:  fn = `ALU_OR;
            default: fn = `ALU_AND;
        endcase
        return fn;
    endfunction

    logic            w_f7_zero;
    logic            w_f7_alt;
    logic            w_is_shift;
    logic [3:0]      w_alufn;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [4:0]      w_shamt;
    logic            w_ill;

    assign w_f7_zero  = (id_funct7 == 7'b0000000);
    assign w_f7_alt   = (id_funct7 == 7'b0100000);
    assign w_is_shift = (id_funct3 == 3'b001) || (id_funct3 == 3'b101);

    // Illegal encodings fall through the defaults: ADD, a=rs1, b=0.
    always_comb begin
        w_alufn = `ALU_ADD;
        w_a     = id_rs1;
        w_b     = '0;
        w_shamt = '0;
        w_ill   = 1'b0;
        unique case (id_opcode)
            OP_R: begin
                if (!(w_f7_zero || w_f7_alt) ||
                    (w_f7_alt && id_funct3 != 3'b000 && id_funct3 != 3'b101)) begin
                    w_ill = 1'b1;
                end else begin
                    w_alufn = f3_alufn(id_funct3, w_f7_alt, 1'b1);
                    w_b     = id_rs2;
                    if (w_is_shift) w_shamt = id_rs2[4:0];
                end
            end
            OP_I: begin
                if ((id_funct3 == 3'b001 && !w_f7_zero) ||
                    (id_funct3 == 3'b101 && !(w_f7_zero || w_f7_alt))) begin
                    w_ill = 1'b1;
                end else begin
                    w_alufn = f3_alufn(id_funct3, w_f7_alt, 1'b0);
                    w_b     = id_imm;
                    if (w_is_shift) w_shamt = id_imm[4:0];
                end
            end
            OP_LUI: begin
                w_alufn = `ALU_PASS;
                w_a     = '0;
                w_b     = id_imm;
            end
            OP_AUIPC, OP_JAL: begin
                w_a = id_pc;
                w_b = id_imm;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                w_b = id_imm;
            end
            OP_BR: begin
                w_alufn = `ALU_SUB;
                w_b     = id_rs2;
            end
            default: w_ill = 1'b1;
        endcase
    end

    logic            r_valid;
    logic [3:0]      r_alufn;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_shamt;
    logic [XLEN-1:0] r_pc;
    logic            r_ill;

    // Flush beats stall; a non-valid decode slot loads the same bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_alufn <= `ALU_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_shamt <= '0;
            r_pc    <= PC_RESET;
            r_ill   <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            r_valid <= 1'b0;
            r_alufn <= `ALU_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_shamt <= '0;
            r_pc    <= id_pc;
            r_ill   <= 1'b0;
        end else if (!stall) begin
            r_valid <= 1'b1;
            r_alufn <= w_alufn;
            r_a     <= w_a;
            r_b     <= w_b;
            r_shamt <= w_shamt;
            r_pc    <= id_pc;
            r_ill   <= w_ill;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_alufn   = r_alufn;
    assign ex_a       = r_a;
    assign ex_b       = r_b;
    assign ex_shamt   = r_shamt;
    assign ex_pc      = r_pc;
    assign ex_illegal = r_ill;

endmodule

// File: tb/tb_prv32_alu_ctrl_stage.sv
// Directed self-checking bench for prv32_alu_ctrl_stage.
`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SUB  4'b0001
`define ALU_PASS 4'b0011
`define ALU_OR   4'b0100
`define ALU_AND  4'b0101
`define ALU_XOR  4'b0111
`define ALU_SRL  4'b1000
`define ALU_SLL  4'b1001
`define ALU_SRA  4'b1010
`define ALU_SLT  4'b1101
`define ALU_SLTU 4'b1111
`endif

module tb_prv32_alu_ctrl_stage;

    localparam logic [31:0] PCR = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic [6:0]  id_funct7 = '0;
    logic [31:0] id_rs1 = '0;
    logic [31:0] id_rs2 = '0;
    logic [31:0] id_imm = '0;
    logic [31:0] id_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_alufn;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    int checks = 0;
    int failures = 0;

    prv32_alu_ctrl_stage #(.XLEN(32), .PC_RESET(PCR)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_imm(id_imm), .id_pc(id_pc), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alufn(ex_alufn), .ex_a(ex_a),
        .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_pc(ex_pc),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [3:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh,
                           input logic [31:0] pc, input logic ill);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".alufn"}, {28'd0, ex_alufn}, {28'd0, fn});
        chk({tag, ".a"}, ex_a, a);
        chk({tag, ".b"}, ex_b, b);
        chk({tag, ".shamt"}, {27'd0, ex_shamt}, {27'd0, sh});
        chk({tag, ".pc"}, ex_pc, pc);
        chk({tag, ".ill"}, {31'd0, ex_illegal}, {31'd0, ill});
    endtask

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        id_valid  = v;
        id_opcode = op;
        id_funct3 = f3;
        id_funct7 = f7;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_imm    = imm;
        id_pc     = pc;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_out("rst0", 0, `ALU_ADD, 0, 0, 0, PCR, 0);
        #1 rst = 1'b1;

        drive(1, 7'b0110011, 3'b000, 7'h00, 32'd1, 32'd2, 32'd9, 32'h10);
        step;
        chk_out("add", 1, `ALU_ADD, 1, 2, 0, 32'h10, 0);

        // async reset mid-cycle with a valid instruction presented
        #2 rst = 1'b0;
        #1 chk_out("rst_async", 0, `ALU_ADD, 0, 0, 0, PCR, 0);
        #2 rst = 1'b1;

        drive(1, 7'b0110011, 3'b000, 7'h20, 32'd5, 32'd7, 32'd0, 32'h20);
        step;
        chk_out("sub", 1, `ALU_SUB, 5, 7, 0, 32'h20, 0);

        drive(1, 7'b0110011, 3'b001, 7'h00, 32'h80, 32'h23, 32'd0, 32'h24);
        step;
        chk_out("sll", 1, `ALU_SLL, 32'h80, 32'h23, 5'd3, 32'h24, 0);

        drive(1, 7'b0010011, 3'b101, 7'h20, 32'hF000_0000, 32'd0,
              32'h403, 32'h28);
        step;
        chk_out("srai", 1, `ALU_SRA, 32'hF000_0000, 32'h403, 5'd3, 32'h28, 0);

        drive(1, 7'b0010011, 3'b000, 7'h40, 32'd4, 32'd0,
              32'hFFFF_F800, 32'h2C);
        step;
        chk_out("addi_neg", 1, `ALU_ADD, 4, 32'hFFFF_F800, 0, 32'h2C, 0);

        drive(1, 7'b0110111, 3'b000, 7'h00, 32'h77, 32'h88,
              32'hABCD_E000, 32'hFC);
        step;
        chk_out("lui", 1, `ALU_PASS, 0, 32'hABCD_E000, 0, 32'hFC, 0);

        drive(1, 7'b0010111, 3'b000, 7'h00, 32'h77, 32'h88,
              32'h1000, 32'h100);
        step;
        chk_out("auipc", 1, `ALU_ADD, 32'h100, 32'h1000, 0, 32'h100, 0);

        drive(1, 7'b1100011, 3'b001, 7'h00, 32'h9, 32'hA, 32'h20, 32'h104);
        step;
        chk_out("branch", 1, `ALU_SUB, 32'h9, 32'hA, 0, 32'h104, 0);

        drive(1, 7'b0000011, 3'b010, 7'h00, 32'h1000, 32'h5, 32'h1F, 32'h108);
        step;
        chk_out("load", 1, `ALU_ADD, 32'h1000, 32'h1F, 0, 32'h108, 0);

        drive(1, 7'b0110011, 3'b100, 7'h00, 32'h11, 32'h22, 32'd0, 32'h40);
        step;
        chk_out("xor", 1, `ALU_XOR, 32'h11, 32'h22, 0, 32'h40, 0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 7'b0010011, 3'(i), 7'h00, 32'(i + 100),
                  32'd3, 32'd6, 32'(i + 200));
            step;
            chk_out("stall", 1, `ALU_XOR, 32'h11, 32'h22, 0, 32'h40, 0);
        end

        flush = 1'b1;
        drive(1, 7'b0110011, 3'b111, 7'h00, 32'h5, 32'h6, 32'd0, 32'h50);
        step;
        chk_out("stall_flush", 0, `ALU_ADD, 0, 0, 0, 32'h50, 0);
        flush = 1'b0;
        stall = 1'b0;

        drive(0, 7'b0110011, 3'b110, 7'h00, 32'h5, 32'h6, 32'd0, 32'h60);
        step;
        chk_out("bubble", 0, `ALU_ADD, 0, 0, 0, 32'h60, 0);

        drive(1, 7'b1111111, 3'b000, 7'h00, 32'h33, 32'h44, 32'h55, 32'h70);
        step;
        chk_out("ill_op", 1, `ALU_ADD, 32'h33, 0, 0, 32'h70, 1);

        drive(1, 7'b0110011, 3'b001, 7'h01, 32'h34, 32'h45, 32'h56, 32'h74);
        step;
        chk_out("ill_f7", 1, `ALU_ADD, 32'h34, 0, 0, 32'h74, 1);

        drive(1, 7'b0110011, 3'b100, 7'h20, 32'h35, 32'h46, 32'h57, 32'h78);
        step;
        chk_out("ill_alt", 1, `ALU_ADD, 32'h35, 0, 0, 32'h78, 1);

        drive(1, 7'b0010011, 3'b001, 7'h20, 32'h36, 32'h47, 32'h401, 32'h7C);
        step;
        chk_out("ill_slli", 1, `ALU_ADD, 32'h36, 0, 0, 32'h7C, 1);

        drive(1, 7'b0110011, 3'b111, 7'h00, 32'hF0, 32'h3C, 32'd0, 32'h80);
        step;
        chk_out("and_clr", 1, `ALU_AND, 32'hF0, 32'h3C, 0, 32'h80, 0);

        // reset asserted while stalled still takes effect immediately
        stall = 1'b1;
        #2 rst = 1'b0;
        #1 chk_out("rst_stall", 0, `ALU_ADD, 0, 0, 0, PCR, 0);
        #2 rst = 1'b1;
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
